// File: rtl/nonogram_pkg.sv
// Shared types and helpers for the nonogram line-elimination engine.
// Optional statistics outputs are enabled with NONOGRAM_STATS_EN.
package nonogram_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_HEADER = 3'd1;
    localparam state_t S_OPTS   = 3'd2;
    localparam state_t S_COMMIT = 3'd3;
    localparam state_t S_DONE   = 3'd4;
    localparam state_t S_ERROR  = 3'd5;

    typedef logic [15:0] stat_t;

    function automatic int line_w(input int size);
        return $clog2(2 * size);
    endfunction

endpackage

// File: rtl/nonogram_line_engine_if.sv
// Option FIFO pop side and push-back side of the line engine.
// Optional statistics outputs are enabled with NONOGRAM_STATS_EN.
interface nonogram_line_engine_if #(
    parameter int SIZE = 3
) ();
    logic [SIZE-1:0] fifo_data;
    logic            fifo_valid;
    logic            fifo_ready;
    logic [SIZE-1:0] out_data;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output fifo_data, fifo_valid, out_ready,
        input  fifo_ready, out_data, out_valid
    );

    modport slave (
        input  fifo_data, fifo_valid, out_ready,
        output fifo_ready, out_data, out_valid
    );
endinterface

// File: rtl/nonogram_line_view.sv
// Extracts one row or transposed column of the board and flags an option
// that contradicts already-known cells.
module nonogram_line_view
    import nonogram_pkg::*;
#(
    parameter int SIZE = 3,
    localparam int LW  = line_w(SIZE)
) (
    input  logic [SIZE*SIZE-1:0] known,
    input  logic [SIZE*SIZE-1:0] assigned,
    input  logic [LW-1:0]        idx,
    input  logic [SIZE-1:0]      opt,
    output logic [SIZE-1:0]      line_known,
    output logic [SIZE-1:0]      line_assigned,
    output logic                 contra
);
    localparam int NL = 2 * SIZE;

    logic [SIZE-1:0] vk [NL];
    logic [SIZE-1:0] va [NL];

    for (genvar l = 0; l < NL; l++) begin : g_l
        for (genvar i = 0; i < SIZE; i++) begin : g_i
            if (l < SIZE) begin : g_row
                assign vk[l][i] = known[l*SIZE+i];
                assign va[l][i] = assigned[l*SIZE+i];
            end else begin : g_col
                assign vk[l][i] = known[i*SIZE+l-SIZE];
                assign va[l][i] = assigned[i*SIZE+l-SIZE];
            end
        end
    end

    always_comb begin
        line_known    = '0;
        line_assigned = '0;
        for (int l = 0; l < NL; l++) begin
            if (idx == LW'(l)) begin
                line_known    = vk[l];
                line_assigned = va[l];
            end
        end
        contra = |(line_known & (opt ^ line_assigned));
    end
endmodule

// File: rtl/nonogram_line_engine.sv
// Streaming line-elimination engine: filters options against the board and
// commits forced cells. NONOGRAM_STATS_EN adds pass_cnt/elim_cnt outputs.
module nonogram_line_engine
    import nonogram_pkg::*;
#(
    parameter int SIZE  = 3,
    parameter int CNT_W = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2*SIZE*CNT_W-1:0] init_amnt,
    nonogram_line_engine_if.slave   bus,
    output logic [SIZE*SIZE-1:0]    known,
    output logic [SIZE*SIZE-1:0]    assigned,
    output logic                    busy,
    output logic                    solved,
    output logic                    stuck,
    output logic                    error
`ifdef NONOGRAM_STATS_EN
    ,
    output stat_t                   pass_cnt,
    output stat_t                   elim_cnt
`endif
);
    localparam int LW = line_w(SIZE);
    localparam int NL = 2 * SIZE;
    localparam int DW = $clog2(NL + 1);

    state_t            state;
    logic [LW-1:0]     idx_q;
    logic [CNT_W-1:0]  left_q;
    logic [CNT_W-1:0]  surv_q;
    logic [SIZE-1:0]   and1_q;
    logic [SIZE-1:0]   and0_q;
    logic [CNT_W-1:0]  cnt_q [NL];
    logic              prog_q;
    logic [DW-1:0]     done_q;

    logic [LW-1:0]     hdr_idx;
    logic [CNT_W-1:0]  hdr_cnt;
    logic              hdr_bad;
    logic              contra;
    logic              pop;
    logic [SIZE-1:0]   lk;
    logic [SIZE-1:0]   la;
    logic [SIZE-1:0]   lk_nxt;
    logic [SIZE-1:0]   la_nxt;
    logic [SIZE*SIZE-1:0] known_nxt;
    logic [SIZE*SIZE-1:0] assigned_nxt;
    logic              prog_nxt;
    logic [DW-1:0]     done_nxt;

    nonogram_line_view #(
        .SIZE(SIZE)
    ) u_view (
        .known        (known),
        .assigned     (assigned),
        .idx          (idx_q),
        .opt          (bus.fifo_data),
        .line_known   (lk),
        .line_assigned(la),
        .contra       (contra)
    );

    assign hdr_idx = bus.fifo_data[LW-1:0];

    // Out-of-range indices fall through to a zero count, which is also an error.
    always_comb begin
        hdr_cnt = '0;
        for (int l = 0; l < NL; l++) begin
            if (hdr_idx == LW'(l)) hdr_cnt = cnt_q[l];
        end
        hdr_bad = (hdr_cnt == '0);
    end

    always_comb begin
        bus.fifo_ready = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_data   = bus.fifo_data;
        unique case (state)
            S_HEADER, S_OPTS: begin
                if ((state == S_HEADER) ? hdr_bad : contra) begin
                    bus.fifo_ready = 1'b1;
                end else begin
                    bus.out_valid  = bus.fifo_valid;
                    bus.fifo_ready = bus.out_ready;
                end
            end
            default: ;
        endcase
    end

    assign pop  = bus.fifo_valid & bus.fifo_ready;
    assign busy = (state == S_HEADER) | (state == S_OPTS) |
                  (state == S_COMMIT);

    assign lk_nxt   = lk | and1_q | and0_q;
    assign la_nxt   = (la | and1_q) & ~and0_q;
    assign prog_nxt = prog_q | (|(lk_nxt & ~lk));
    assign done_nxt = done_q + DW'(1);

    for (genvar r = 0; r < SIZE; r++) begin : g_r
        for (genvar c = 0; c < SIZE; c++) begin : g_c
            logic hr;
            logic hc;
            assign hr = (idx_q == LW'(r));
            assign hc = (idx_q == LW'(SIZE + c));
            assign known_nxt[r*SIZE+c] =
                hr ? lk_nxt[c] : hc ? lk_nxt[r] : known[r*SIZE+c];
            assign assigned_nxt[r*SIZE+c] =
                hr ? la_nxt[c] : hc ? la_nxt[r] : assigned[r*SIZE+c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            idx_q    <= '0;
            left_q   <= '0;
            surv_q   <= '0;
            and1_q   <= '0;
            and0_q   <= '0;
            prog_q   <= 1'b0;
            done_q   <= '0;
            known    <= '0;
            assigned <= '0;
            solved   <= 1'b0;
            stuck    <= 1'b0;
            error    <= 1'b0;
            for (int l = 0; l < NL; l++) cnt_q[l] <= '0;
        end else begin
            unique case (state)
                S_HEADER: begin
                    if (pop) begin
                        if (hdr_bad) begin
                            error <= 1'b1;
                            state <= S_ERROR;
                        end else begin
                            idx_q  <= hdr_idx;
                            left_q <= hdr_cnt;
                            and1_q <= '1;
                            and0_q <= '1;
                            surv_q <= '0;
                            state  <= S_OPTS;
                        end
                    end
                end
                S_OPTS: begin
                    if (pop) begin
                        left_q <= left_q - CNT_W'(1);
                        if (!contra) begin
                            and1_q <= and1_q & bus.fifo_data;
                            and0_q <= and0_q & ~bus.fifo_data;
                            surv_q <= surv_q + CNT_W'(1);
                        end
                        if (left_q == CNT_W'(1)) state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (surv_q == '0) begin
                        error <= 1'b1;
                        state <= S_ERROR;
                    end else begin
                        cnt_q[idx_q] <= surv_q;
                        known        <= known_nxt;
                        assigned     <= assigned_nxt;
                        prog_q       <= prog_nxt;
                        done_q       <= done_nxt;
                        if (&known_nxt) begin
                            solved <= 1'b1;
                            state  <= S_DONE;
                        end else if (done_nxt == DW'(NL)) begin
                            if (!prog_nxt) begin
                                stuck <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                prog_q <= 1'b0;
                                done_q <= '0;
                                state  <= S_HEADER;
                            end
                        end else begin
                            state <= S_HEADER;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        for (int l = 0; l < NL; l++)
                            cnt_q[l] <= init_amnt[l*CNT_W +: CNT_W];
                        known    <= '0;
                        assigned <= '0;
                        solved   <= 1'b0;
                        stuck    <= 1'b0;
                        error    <= 1'b0;
                        prog_q   <= 1'b0;
                        done_q   <= '0;
                        state    <= S_HEADER;
                    end
                end
            endcase
        end
    end

`ifdef NONOGRAM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || (start && !busy)) begin
            pass_cnt <= '0;
            elim_cnt <= '0;
        end else begin
            if (state == S_OPTS && pop && contra && elim_cnt != '1)
                elim_cnt <= elim_cnt + 16'd1;
            if (state == S_COMMIT && surv_q != '0 &&
                done_nxt == DW'(NL) && pass_cnt != '1)
                pass_cnt <= pass_cnt + 16'd1;
        end
    end
`endif
endmodule
